// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed scan of NDIG hex digits through one shared
// 7-seg decoder, with a req/ack frame loader that commits only at frame boundaries.
`default_nettype none

module seg_scan_controller #(
  parameter int NDIG  = 4,
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [4*NDIG-1:0]   load_val_i,
  input  logic [NDIG-1:0]     load_en_i,
  input  logic                load_req_i,
  output logic                load_ack_o,
  output logic [3:0]          seg_val_o,
  output logic [NDIG-1:0]     dig_sel_o,
  output logic                frame_end_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NDIG-1:0][3:0]   act_val_q, act_val_d;
  logic [NDIG-1:0]        act_en_q, act_en_d;
  logic [NDIG-1:0][3:0]   sh_val_q, sh_val_d;
  logic [NDIG-1:0]        sh_en_q, sh_en_d;
  logic                   pending_q, pending_d;
  logic                   load_ack_q, load_ack_d;
  logic [3:0]             seg_val_q, seg_val_d;
  logic [NDIG-1:0]        dig_sel_q, dig_sel_d;
  logic                   frame_end_q, frame_end_d;
  logic                   blank_d;
  logic                   commit, capture;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Outputs are computed from the next (cnt, idx) so the registered values line up
  // with the slot position they describe.
  if (BLANK == 0) begin : g_no_blank
    assign blank_d = 1'b0;
  end else begin : g_blank
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    assign blank_d = (cnt_d < BLANK_C);
  end

  always_comb begin
    // frame_end_q marks the last cycle of the frame, so this edge is the frame boundary
    commit  = frame_end_q & pending_q;
    capture = load_req_i & ~pending_q & ~load_ack_q;

    act_val_d  = act_val_q;
    act_en_d   = act_en_q;
    sh_val_d   = sh_val_q;
    sh_en_d    = sh_en_q;
    pending_d  = pending_q;
    load_ack_d = 1'b0;

    if (commit) begin
      act_val_d  = sh_val_q;
      act_en_d   = sh_en_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end else if (capture) begin
      sh_val_d  = load_val_i;
      sh_en_d   = load_en_i;
      pending_d = 1'b1;
    end

    frame_end_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    seg_val_d   = act_val_d[idx_d];
    dig_sel_d   = '0;
    if (!blank_d && act_en_d[idx_d]) begin
      dig_sel_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      act_val_q   <= '0;
      act_en_q    <= '0;
      sh_val_q    <= '0;
      sh_en_q     <= '0;
      pending_q   <= 1'b0;
      load_ack_q  <= 1'b0;
      seg_val_q   <= '0;
      dig_sel_q   <= '0;
      frame_end_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_en_q    <= act_en_d;
      sh_val_q    <= sh_val_d;
      sh_en_q     <= sh_en_d;
      pending_q   <= pending_d;
      load_ack_q  <= load_ack_d;
      seg_val_q   <= seg_val_d;
      dig_sel_q   <= dig_sel_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign load_ack_o  = load_ack_q;
  assign seg_val_o   = seg_val_q;
  assign dig_sel_o   = dig_sel_q;
  assign frame_end_o = frame_end_q;

endmodule

`default_nettype wire
